// File: rtl/usb_tx_pkg.sv
// Constants and types shared by the USB transmitter, its payload FIFO and the SD-side source.
package usb_tx_pkg;

  localparam int unsigned USB_BYTE_W        = 8;
  localparam int unsigned USB_TX_FIFO_DEPTH = 64;

  typedef logic [USB_BYTE_W-1:0] usb_byte_t;

endpackage

// File: rtl/fifo_regfile.sv
// Register-array storage for the TX FIFO: synchronous write port, asynchronous read port.
module fifo_regfile import usb_tx_pkg::*; #(
  parameter int unsigned DATA_WIDTH = USB_BYTE_W,
  parameter int unsigned DEPTH      = USB_TX_FIFO_DEPTH,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Contents are deliberately not reset; unoccupied entries are don't-care.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/usb_tx_fifo.sv
// First-word-fall-through payload FIFO between the SD data source and the USB transmitter.
module usb_tx_fifo import usb_tx_pkg::*; #(
  parameter int unsigned DATA_WIDTH      = USB_BYTE_W,
  parameter int unsigned DEPTH           = USB_TX_FIFO_DEPTH,
  parameter int unsigned ADDR_WIDTH      = $clog2(DEPTH),
  parameter int unsigned ALMOST_FULL_LVL = DEPTH - 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  flush,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_CNT   = (ADDR_WIDTH + 1)'(ALMOST_FULL_LVL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  rd_accept;
  logic                  wr_accept;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign almost_full = (count_q >= AF_CNT);

  // A write into a full FIFO is only legal when a pop frees the slot in the same cycle.
  assign rd_accept = read_enable && !empty;
  assign wr_accept = write_enable && (!full || rd_accept);
  assign mem_wen   = wr_accept && !flush;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_accept) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      if (rd_accept) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      if (wr_accept && !rd_accept) begin
        count_d = count_q + CNT_ONE;
      end else if (rd_accept && !wr_accept) begin
        count_d = count_q - CNT_ONE;
      end
      if (write_enable && !wr_accept) begin
        overflow_d = 1'b1;
      end
      if (read_enable && !rd_accept) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clk   (clk),
    .wen   (mem_wen),
    .waddr (wptr_q),
    .wdata (write_data),
    .raddr (rptr_q),
    .rdata (mem_rdata)
  );

  assign read_data = empty ? '0 : mem_rdata;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_usb_tx_fifo.sv
// Self-checking bench for usb_tx_fifo: directed steps plus random traffic against a queue model.
module tb_usb_tx_fifo;

  localparam int DEPTH  = 64;
  localparam int AF_LVL = 60;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       flush = 1'b0;
  logic       write_enable = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic       read_enable = 1'b0;
  logic [7:0] read_data;
  logic       empty, full, almost_full, overflow, underflow;
  logic [6:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;

  always #5 clk = ~clk;

  usb_tx_fifo dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .flush        (flush),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: a byte queue with sticky error bits.
  task automatic model_step(input bit f, input bit we, input logic [7:0] wd, input bit re);
    bit rd_ok, wr_ok;
    if (f) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    rd_ok = re && (q.size() > 0);
    wr_ok = we && ((q.size() < DEPTH) || rd_ok);
    if (re && !rd_ok) m_unf = 1'b1;
    if (we && !wr_ok) m_ovf = 1'b1;
    if (rd_ok) void'(q.pop_front());
    if (wr_ok) q.push_back(wd);
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_rd;
    exp_rd = (q.size() > 0) ? q[0] : 8'h00;
    check({tag, ".count"},       32'(count),       32'(q.size()));
    check({tag, ".empty"},       32'(empty),       32'(q.size() == 0));
    check({tag, ".full"},        32'(full),        32'(q.size() == DEPTH));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(q.size() >= AF_LVL));
    check({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
    check({tag, ".underflow"},   32'(underflow),   32'(m_unf));
    check({tag, ".read_data"},   32'(read_data),   32'(exp_rd));
  endtask

  task automatic step(input bit f, input bit we, input logic [7:0] wd, input bit re,
                      input string tag);
    flush        = f;
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    @(posedge clk);
    #1;
    model_step(f, we, wd, re);
    flush        = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] seq [3];
    int         r;
    seq[0] = 8'hA5;
    seq[1] = 8'h3C;
    seq[2] = 8'hFF;

    #12;
    check_all("reset");
    check("reset.read_data_lit", 32'(read_data), 32'h0);
    #11;
    n_rst = 1'b1;

    // Three writes, then three pops
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, seq[i], 1'b0, "tp1.wr");
      check("tp1.count_lit", 32'(count), 32'(i + 1));
      check("tp1.head_lit", 32'(read_data), 32'hA5);
    end
    for (int i = 0; i < 3; i++) begin
      check("tp1.pop_lit", 32'(read_data), 32'(seq[i]));
      step(1'b0, 1'b0, 8'h00, 1'b1, "tp1.rd");
    end
    check("tp1.empty_lit", 32'(empty), 32'h1);
    check("tp1.rd0_lit", 32'(read_data), 32'h0);

    // Fill to full, overflow, drain
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0, "tp2.fill");
      check("tp2.af_lit", 32'(almost_full), 32'(i + 1 >= 60));
    end
    check("tp2.full_lit", 32'(full), 32'h1);
    step(1'b0, 1'b1, 8'hEE, 1'b0, "tp2.ovf");
    check("tp2.ovf_lit", 32'(overflow), 32'h1);
    check("tp2.cnt64_lit", 32'(count), 32'd64);
    for (int i = 0; i < DEPTH; i++) begin
      check("tp2.drain_lit", 32'(read_data), 32'(i));
      step(1'b0, 1'b0, 8'h00, 1'b1, "tp2.drain");
    end
    step(1'b1, 1'b0, 8'h00, 1'b0, "tp2.flush");

    // Simultaneous read/write while full
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'(i + 8'h40), 1'b0, "tp3.fill");
    step(1'b0, 1'b1, 8'h77, 1'b1, "tp3.rw");
    check("tp3.cnt_lit", 32'(count), 32'd64);
    check("tp3.ovf_lit", 32'(overflow), 32'h0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b0, 8'h00, 1'b1, "tp3.pop");
    check("tp3.tail_lit", 32'(read_data), 32'h77);
    step(1'b0, 1'b0, 8'h00, 1'b1, "tp3.last");

    // Simultaneous read/write while empty: no bypass
    step(1'b0, 1'b1, 8'h5A, 1'b1, "tp4.rw");
    check("tp4.unf_lit", 32'(underflow), 32'h1);
    check("tp4.cnt_lit", 32'(count), 32'd1);
    check("tp4.rd_lit", 32'(read_data), 32'h5A);
    step(1'b0, 1'b0, 8'h00, 1'b1, "tp4.pop");

    // Flush beats a simultaneous write
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, "tp5.fill");
    step(1'b1, 1'b1, 8'h99, 1'b0, "tp5.flush");
    check("tp5.cnt_lit", 32'(count), 32'd0);
    check("tp5.empty_lit", 32'(empty), 32'h1);
    check("tp5.unf_lit", 32'(underflow), 32'h0);
    step(1'b0, 1'b1, 8'h11, 1'b0, "tp5.wr");
    check("tp5.head_lit", 32'(read_data), 32'h11);
    step(1'b0, 1'b0, 8'h00, 1'b1, "tp5.pop");

    // Asynchronous reset mid-packet
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'hD0 + i), 1'b0, "tp6.fill");
    #3;
    n_rst = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_all("tp6.async_rst");
    check("tp6.empty_lit", 32'(empty), 32'h1);
    @(posedge clk);
    #3;
    n_rst = 1'b1;

    // Write/read pairs across pointer wrap
    for (int i = 0; i < 100; i++) begin
      d = 8'($urandom);
      step(1'b0, 1'b1, d, 1'b0, "tp7.wr");
      check("tp7.head", 32'(read_data), 32'(d));
      step(1'b0, 1'b0, 8'h00, 1'b1, "tp7.rd");
    end

    // Random mixed traffic, write-biased then read-biased phases
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      step(($urandom_range(0, 199) == 0),
           (r < ((i / 500) % 2 == 0 ? 70 : 35)),
           8'($urandom),
           ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 35 : 70)),
           "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_tx_fifo.md
# usb_tx_fifo

Byte-wide first-word-fall-through FIFO that buffers packet payload between the SD-side data source and the USB transmitter. It is written by the SD interface logic and read by the transmitter: the transmitter's `load_enable_sd` pulse pops one byte, and the FIFO's `empty` flag tells the transmitter's control unit when the payload is exhausted. The block sits directly upstream of the transmitter and feeds its `empty` input and payload byte.

## Interface
- `DATA_WIDTH`, default 8: payload byte width.
- `DEPTH`, default 64: number of entries; must be a power of two, at least 4.
- `ADDR_WIDTH`, default $clog2(DEPTH): pointer width. Derived; not overridden.
- `ALMOST_FULL_LVL`, default DEPTH-4: occupancy at or above which `almost_full` asserts.

Ports:
- `clk` input 1: single clock. All state changes on its rising edge.
- `n_rst` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous clear of contents and sticky flags.
- `write_enable` input 1: push `write_data` this cycle.
- `write_data` input DATA_WIDTH: byte to push.
- `read_enable` input 1: pop the head entry. Tied to the transmitter's `load_enable_sd`.
- `read_data` output DATA_WIDTH: head entry. Forced to 0 while `empty`.
- `empty` output 1: occupancy is 0.
- `full` output 1: occupancy equals DEPTH.
- `almost_full` output 1: occupancy is at least ALMOST_FULL_LVL.
- `count` output ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- `overflow` output 1: sticky; set when a write is attempted while full.
- `underflow` output 1: sticky; set when a read is attempted while empty.

## Operation
- Storage is a DEPTH-entry register array with a write pointer and a read pointer, each ADDR_WIDTH bits wide. Pointers wrap modulo DEPTH with natural binary rollover.
- `count` is held in its own register of ADDR_WIDTH+1 bits. `empty` and `full` decode from `count`, never from pointer compare.
- A write is accepted when `write_enable` is high and either:
  - the FIFO is not full, or
  - the FIFO is full and an accepted read happens in the same cycle.
- A read is accepted when `read_enable` is high and the FIFO is not empty. A read on an empty FIFO is ignored, even if a write happens in the same cycle; there is no bypass.
- Accepted write: `mem[wptr] <= write_data`, then `wptr` increments.
- Accepted read: `rptr` increments.
- `count` update:
  - write only: +1
  - read only: −1
  - both, or neither: unchanged
- Rejected write: `overflow` sets to 1 and stays set. The data is dropped and the pointers are unchanged.
- Rejected read: `underflow` sets to 1 and stays set.
- `read_data` = `mem[rptr]` when not empty, else 0 (combinational from registered state).
- `flush` takes priority over everything else in the same cycle. On the next edge, pointers, `count`, `overflow` and `underflow` clear to 0. Any simultaneous read or write is discarded and does not set the sticky flags.
- Array contents are not reset. They are don't-care while their entry is unoccupied.

## Timing
- Reset values: `empty`=1, `full`=0, `almost_full`=0, `count`=0, `overflow`=0, `underflow`=0, `read_data`=0. Pointers reset to 0.
- Write-to-read latency is 1 cycle. A byte written at edge N is on `read_data`, with `empty`=0, just after edge N.
- Pop latency: after an accepted read at edge N, the next entry (or 0 if now empty) shows on `read_data` just after edge N.
- Flags and `count` are all updated on the same edge as the pointer change. No flag lags `count`.
- Back-to-back reads and writes are sustainable every cycle.
- Reset asserted mid-packet: all state returns to reset values immediately, without waiting for a clock edge.
- Wrap-around: after DEPTH writes and DEPTH reads, both pointers are back at 0 and behaviour is identical to after reset.

## Structure
- Shared package `usb_tx_pkg`:
  - `USB_BYTE_W` = 8
  - `USB_TX_FIFO_DEPTH` = 64
  - typedef `usb_byte_t` = logic [7:0]
  - The transmitter and SD-side logic import the same constants.
- One sub-module, `fifo_regfile`: a parameterised DATA_WIDTH × DEPTH register array with synchronous write port (`wen`, `waddr`, `wdata`) and asynchronous read port (`raddr`, `rdata`). Pointer, count and flag logic stay in `usb_tx_fifo`.

## Test plan
- Reset, then write 0xA5, 0x3C, 0xFF on consecutive cycles:
  - `count` goes 1, 2, 3.
  - `read_data`=0xA5 one cycle after the first write.
  - Popping three times yields 0xA5, 0x3C, 0xFF, then `empty`=1 and `read_data`=0.
- Fill with 0x00..0x3F (64 writes):
  - `almost_full` rises when `count`=60.
  - `full`=1 at `count`=64.
  - A 65th write sets `overflow` and leaves `count`=64.
  - Draining returns 0x00..0x3F in order.
- While full, assert read and write together with `write_data`=0x77:
  - `count` stays 64 and `overflow` stays 0.
  - After 63 pops, `read_data`=0x77.
- While empty, assert read and write together with 0x5A:
  - `underflow`=1.
  - `count`=1 and `read_data`=0x5A next cycle.
- With `count`=10, pulse `flush` together with `write_enable`:
  - Next cycle `count`=0, `empty`=1, and both sticky flags are 0.
  - The next write of 0x11 appears at the head.
- Write 5 entries, then drop `n_rst` between edges:
  - Outputs go to their reset values asynchronously.
  - 100 write/read pairs afterwards check ordering across pointer wrap.
